// File: rtl/spi_master_sequencer_pkg.sv
// Shared types and constants for the SPI master sequencer.
package spi_pkg;

  localparam int DEFAULT_DATA_WIDTH = 8;

  localparam logic [1:0] RATE_DIV2  = 2'd0;
  localparam logic [1:0] RATE_DIV4  = 2'd1;
  localparam logic [1:0] RATE_DIV8  = 2'd2;
  localparam logic [1:0] RATE_DIV16 = 2'd3;

  typedef enum logic [2:0] {
    IDLE,
    SETUP,
    XFER,
    GAP,
    HOLD
  } state_e;

endpackage

// File: rtl/spi_master_sequencer_shift_reg.sv
// TX/RX shift datapath and bit counter for one SPI word.
// Bit order is latched per word from lsb_first_i.
module spi_shift_reg
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  load_i,
  input  logic                  sample_i,
  input  logic                  shift_i,
  input  logic                  clear_i,
  input  logic                  lsb_first_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  miso_i,
  output logic                  mosi_o,
  output logic [DATA_WIDTH-1:0] rx_o,
  output logic                  done_o
);

  localparam int CNT_W = $clog2(DATA_WIDTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(DATA_WIDTH);

  logic [DATA_WIDTH-1:0] tx_q;
  logic [DATA_WIDTH-1:0] rx_q;
  logic [CNT_W-1:0]      bit_cnt_q;
  logic                  mosi_q;
  logic                  lsb_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      tx_q      <= '0;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      mosi_q    <= 1'b0;
      lsb_q     <= 1'b0;
    end else if (load_i) begin
      tx_q      <= data_i;
      rx_q      <= '0;
      bit_cnt_q <= '0;
      lsb_q     <= lsb_first_i;
      mosi_q    <= lsb_first_i ? data_i[0] : data_i[DATA_WIDTH-1];
    end else begin
      if (sample_i) begin
        rx_q <= lsb_q ? {miso_i, rx_q[DATA_WIDTH-1:1]} : {rx_q[DATA_WIDTH-2:0], miso_i};
        // saturate so the count never wraps on a stray strobe
        if (bit_cnt_q != FULL) bit_cnt_q <= bit_cnt_q + CNT_W'(1);
      end
      if (shift_i) begin
        tx_q   <= lsb_q ? (tx_q >> 1) : (tx_q << 1);
        mosi_q <= lsb_q ? tx_q[1] : tx_q[DATA_WIDTH-2];
      end
      if (clear_i) mosi_q <= 1'b0;
    end
  end

  assign mosi_o = mosi_q;
  assign rx_o   = rx_q;
  assign done_o = (bit_cnt_q == FULL);

endmodule

// File: rtl/spi_master_sequencer.sv
// SPI mode-0 master sequencer around an external clock generator.
// Optional macro SPI_LSB_FIRST_EN adds the i_lsb_first bit-order input.
//
// state | meaning
// IDLE  | cs_n high, ready for the first word of a frame
// SETUP | cs_n low, CS setup countdown, restart then enable generator
// XFER  | generator running, sample on rise, shift on fall
// GAP   | between words of a frame, cs_n held low, ready for next word
// HOLD  | CS hold countdown after the last word, then release cs_n
module spi_master_sequencer
  import spi_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int CS_SETUP   = 2,
  parameter int CS_HOLD    = 2
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic                  i_tx_valid,
  output logic                  o_tx_ready,
  input  logic [DATA_WIDTH-1:0] i_tx_data,
  input  logic                  i_tx_last,
  input  logic [1:0]            i_rate,
`ifdef SPI_LSB_FIRST_EN
  input  logic                  i_lsb_first,
`endif
  output logic                  o_rx_valid,
  output logic [DATA_WIDTH-1:0] o_rx_data,
  output logic                  o_busy,
  output logic                  o_gen_enable,
  output logic [1:0]            o_gen_rate,
  output logic                  o_gen_restart,
  input  logic                  i_gen_rise,
  input  logic                  i_gen_fall,
  output logic                  o_cs_n,
  output logic                  o_mosi,
  input  logic                  i_miso
);

  state_e                state_q;
  logic [3:0]            cnt_q;
  logic                  last_q;
  logic                  tx_ready_q;
  logic                  rx_valid_q;
  logic [DATA_WIDTH-1:0] rx_data_q;
  logic                  busy_q;
  logic                  gen_enable_q;
  logic [1:0]            gen_rate_q;
  logic                  gen_restart_q;
  logic                  cs_n_q;

  logic                  accept;
  logic                  sample;
  logic                  fall_ok;
  logic                  shift;
  logic                  word_done;
  logic                  clear;
  logic                  lsb_first;
  logic                  word_full;
  logic [DATA_WIDTH-1:0] rx_word;

`ifdef SPI_LSB_FIRST_EN
  assign lsb_first = i_lsb_first;
`else
  assign lsb_first = 1'b0;
`endif

  assign accept    = i_tx_valid && tx_ready_q && (state_q == IDLE || state_q == GAP);
  assign sample    = (state_q == XFER) && gen_enable_q && i_gen_rise;
  // a fall coinciding with a rise is dropped
  assign fall_ok   = (state_q == XFER) && gen_enable_q && i_gen_fall && !i_gen_rise;
  assign shift     = fall_ok && !word_full;
  assign word_done = fall_ok && word_full;
  assign clear     = (state_q == HOLD) && (cnt_q == 4'd1);

  spi_shift_reg #(
    .DATA_WIDTH(DATA_WIDTH)
  ) u_shift (
    .clk_i      (i_clk),
    .reset_i    (i_reset),
    .load_i     (accept),
    .sample_i   (sample),
    .shift_i    (shift),
    .clear_i    (clear),
    .lsb_first_i(lsb_first),
    .data_i     (i_tx_data),
    .miso_i     (i_miso),
    .mosi_o     (o_mosi),
    .rx_o       (rx_word),
    .done_o     (word_full)
  );

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      last_q        <= 1'b0;
      tx_ready_q    <= 1'b0;
      rx_valid_q    <= 1'b0;
      rx_data_q     <= '0;
      busy_q        <= 1'b0;
      gen_enable_q  <= 1'b0;
      gen_rate_q    <= RATE_DIV2;
      gen_restart_q <= 1'b0;
      cs_n_q        <= 1'b1;
    end else begin
      gen_restart_q <= 1'b0;
      rx_valid_q    <= 1'b0;
      case (state_q)
        IDLE: begin
          tx_ready_q <= 1'b1;
          cs_n_q     <= 1'b1;
          busy_q     <= 1'b0;
          if (accept) begin
            last_q     <= i_tx_last;
            gen_rate_q <= i_rate;
            tx_ready_q <= 1'b0;
            cs_n_q     <= 1'b0;
            busy_q     <= 1'b1;
            cnt_q      <= 4'(CS_SETUP);
            state_q    <= SETUP;
          end
        end
        SETUP: begin
          if (cnt_q == 4'd0) begin
            gen_enable_q <= 1'b1;
            state_q      <= XFER;
          end else begin
            cnt_q <= cnt_q - 4'd1;
            if (cnt_q == 4'd1) gen_restart_q <= 1'b1;
          end
        end
        XFER: begin
          // entered from GAP with the generator stopped: restart was issued last cycle
          if (!gen_enable_q) begin
            gen_enable_q <= 1'b1;
          end else if (word_done) begin
            gen_enable_q <= 1'b0;
            rx_valid_q   <= 1'b1;
            rx_data_q    <= rx_word;
            if (last_q) begin
              cnt_q   <= 4'(CS_HOLD);
              state_q <= HOLD;
            end else begin
              tx_ready_q <= 1'b1;
              state_q    <= GAP;
            end
          end
        end
        GAP: begin
          if (accept) begin
            last_q        <= i_tx_last;
            tx_ready_q    <= 1'b0;
            gen_restart_q <= 1'b1;
            state_q       <= XFER;
          end
        end
        HOLD: begin
          if (cnt_q == 4'd1) begin
            cs_n_q     <= 1'b1;
            busy_q     <= 1'b0;
            tx_ready_q <= 1'b1;
            state_q    <= IDLE;
          end else begin
            cnt_q <= cnt_q - 4'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign o_tx_ready    = tx_ready_q;
  assign o_rx_valid    = rx_valid_q;
  assign o_rx_data     = rx_data_q;
  assign o_busy        = busy_q;
  assign o_gen_enable  = gen_enable_q;
  assign o_gen_rate    = gen_rate_q;
  assign o_gen_restart = gen_restart_q;
  assign o_cs_n        = cs_n_q;

endmodule

// File: tb/tb_spi_master_sequencer.sv
// Directed bench for spi_master_sequencer with a clock-generator and SPI slave model.
module tb_spi_master_sequencer;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       tx_valid = 1'b0;
  logic       tx_ready;
  logic [7:0] tx_data = 8'h00;
  logic       tx_last = 1'b0;
  logic [1:0] rate = 2'd0;
  logic       lsb_first = 1'b0;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       busy;
  logic       gen_enable;
  logic [1:0] gen_rate;
  logic       gen_restart;
  logic       gen_rise;
  logic       gen_fall;
  logic       cs_n;
  logic       mosi;
  logic       miso;

  int total = 0;
  int bad = 0;

  always #5 clk = ~clk;

  spi_master_sequencer #(
    .DATA_WIDTH(8),
    .CS_SETUP  (2),
    .CS_HOLD   (2)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .i_tx_valid   (tx_valid),
    .o_tx_ready   (tx_ready),
    .i_tx_data    (tx_data),
    .i_tx_last    (tx_last),
    .i_rate       (rate),
`ifdef SPI_LSB_FIRST_EN
    .i_lsb_first  (lsb_first),
`endif
    .o_rx_valid   (rx_valid),
    .o_rx_data    (rx_data),
    .o_busy       (busy),
    .o_gen_enable (gen_enable),
    .o_gen_rate   (gen_rate),
    .o_gen_restart(gen_restart),
    .i_gen_rise   (gen_rise),
    .i_gen_fall   (gen_fall),
    .o_cs_n       (cs_n),
    .o_mosi       (mosi),
    .i_miso       (miso)
  );

  // clock generator model: divide by 2<<rate, rise mid-period, fall at period end
  logic [3:0] ph;
  logic [4:0] div;
  assign div      = 5'd2 << gen_rate;
  assign gen_rise = gen_enable && ({1'b0, ph} == (div >> 1) - 5'd1);
  assign gen_fall = gen_enable && ({1'b0, ph} == div - 5'd1);

  always @(posedge clk) begin
    if (rst || gen_restart) ph <= 4'd0;
    else if (gen_enable) ph <= ({1'b0, ph} == div - 5'd1) ? 4'd0 : ph + 4'd1;
  end

  // slave model: shifts miso_word out MSB first, advancing on each fall
  logic [7:0] miso_word = 8'h00;
  logic [2:0] midx;
  assign miso = miso_word[3'd7 - midx];

  always @(posedge clk) begin
    if (rst || gen_restart) midx <= 3'd0;
    else if (gen_fall && midx != 3'd7) midx <= midx + 3'd1;
  end

  logic [7:0] mosi_cap = 8'h00;
  int rise_cnt = 0;
  int rx_pulses = 0;
  int cs_low_run = 0;
  int cs_low_last = 0;
  int cs_rises = 0;

  always @(posedge clk) begin
    if (rst || gen_restart) begin
      mosi_cap <= 8'h00;
      rise_cnt <= 0;
    end else if (gen_rise) begin
      mosi_cap <= {mosi_cap[6:0], mosi};
      rise_cnt <= rise_cnt + 1;
    end
    if (rx_valid) rx_pulses <= rx_pulses + 1;
    if (cs_n === 1'b0) cs_low_run <= cs_low_run + 1;
    else if (cs_low_run != 0) begin
      cs_low_last <= cs_low_run;
      cs_low_run  <= 0;
      cs_rises    <= cs_rises + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [7:0] d, input logic l, input logic [1:0] r, input logic lsb);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    chk("ready_wait", {31'd0, tx_ready}, 32'd1);
    tx_valid  = 1'b1;
    tx_data   = d;
    tx_last   = l;
    rate      = r;
    lsb_first = lsb;
    @(negedge clk);
    tx_valid = 1'b0;
  endtask

  task automatic wait_rx(output logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!rx_valid && n < 400) begin
      @(negedge clk);
      n++;
    end
    chk("rx_wait", {31'd0, rx_valid}, 32'd1);
    d = rx_data;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (busy && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("idle_wait", {31'd0, busy}, 32'd0);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d;
    int p_cs, p_rx, n;

    repeat (3) @(negedge clk);
    chk("rst_ready", {31'd0, tx_ready}, 32'd0);
    chk("rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("rst_mosi", {31'd0, mosi}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_gen_en", {31'd0, gen_enable}, 32'd0);
    chk("rst_gen_rate", {30'd0, gen_rate}, 32'd0);
    chk("rst_restart", {31'd0, gen_restart}, 32'd0);
    chk("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("rst_rx_data", {24'd0, rx_data}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("ready_after_rst", {31'd0, tx_ready}, 32'd1);

    // single word: 0xA5 out, 0x3C in, rate 0
    miso_word = 8'h3C;
    send(8'hA5, 1'b1, 2'd0, 1'b0);
    chk("setup_cs_n", {31'd0, cs_n}, 32'd0);
    chk("setup_busy", {31'd0, busy}, 32'd1);
    chk("setup_ready", {31'd0, tx_ready}, 32'd0);
    chk("setup_mosi_msb", {31'd0, mosi}, 32'd1);
    wait_rx(d);
    chk("w1_mosi", {24'd0, mosi_cap}, 32'hA5);
    chk("w1_rx", {24'd0, d}, 32'h3C);
    @(negedge clk);
    chk("w1_rx_pulse", {31'd0, rx_valid}, 32'd0);
    wait_idle();
    chk("w1_cs_low", cs_low_last, 32'd21);
    chk("w1_ready_idle", {31'd0, tx_ready}, 32'd1);
    chk("w1_mosi_idle", {31'd0, mosi}, 32'd0);

    // two-word frame: CS stays low through GAP
    p_cs = cs_rises;
    p_rx = rx_pulses;
    miso_word = 8'h81;
    send(8'h12, 1'b0, 2'd0, 1'b0);
    wait_rx(d);
    chk("w2a_mosi", {24'd0, mosi_cap}, 32'h12);
    chk("w2a_rx", {24'd0, d}, 32'h81);
    chk("gap_cs_n", {31'd0, cs_n}, 32'd0);
    chk("gap_ready", {31'd0, tx_ready}, 32'd1);
    miso_word = 8'h7E;
    send(8'h34, 1'b1, 2'd0, 1'b0);
    wait_rx(d);
    chk("w2b_mosi", {24'd0, mosi_cap}, 32'h34);
    chk("w2b_rx", {24'd0, d}, 32'h7E);
    wait_idle();
    chk("w2_cs_rises", cs_rises - p_cs, 32'd1);
    chk("w2_rx_pulses", rx_pulses - p_rx, 32'd2);

    // rate sweep with i_rate disturbed mid-frame
    for (int r = 0; r < 4; r++) begin
      miso_word = 8'h0F;
      send(8'hFF, 1'b1, 2'(r), 1'b0);
      rate = ~2'(r);
      wait_rx(d);
      chk("rate_latched", {30'd0, gen_rate}, r);
      chk("rate_rx", {24'd0, d}, 32'h0F);
      chk("rate_mosi", {24'd0, mosi_cap}, 32'hFF);
      wait_idle();
      chk("rate_cs_low", cs_low_last, 3 + 8 * (2 << r) + 2);
    end

    // reset after bit 4 of a transfer
    miso_word = 8'h00;
    send(8'hF0, 1'b1, 2'd0, 1'b0);
    n = 0;
    while (rise_cnt < 4 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_bit4_wait", {31'd0, rise_cnt >= 4}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_cs_n", {31'd0, cs_n}, 32'd1);
    chk("mid_rst_gen_en", {31'd0, gen_enable}, 32'd0);
    chk("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    rst = 1'b0;
    p_rx = rx_pulses;
    repeat (30) @(negedge clk);
    chk("mid_no_rx", rx_pulses - p_rx, 32'd0);
    miso_word = 8'hA5;
    send(8'h5A, 1'b1, 2'd0, 1'b0);
    wait_rx(d);
    chk("post_rst_mosi", {24'd0, mosi_cap}, 32'h5A);
    chk("post_rst_rx", {24'd0, d}, 32'hA5);
    wait_idle();

    // back-pressure: valid held with changing data while busy
    miso_word = 8'h66;
    p_cs = cs_rises;
    @(negedge clk);
    tx_valid = 1'b1;
    tx_data  = 8'hC3;
    tx_last  = 1'b1;
    rate     = 2'd0;
    n = 0;
    d = 8'h00;
    while (n < 200) begin
      @(negedge clk);
      n++;
      if (rx_valid) begin
        d = rx_data;
        break;
      end
      tx_data = 8'($urandom);
    end
    tx_valid = 1'b0;
    chk("bp_rx_seen", {31'd0, rx_valid}, 32'd1);
    chk("bp_mosi", {24'd0, mosi_cap}, 32'hC3);
    chk("bp_rx", {24'd0, d}, 32'h66);
    wait_idle();
    repeat (5) @(negedge clk);
    chk("bp_one_frame", cs_rises - p_cs, 32'd1);
    chk("bp_idle_busy", {31'd0, busy}, 32'd0);

`ifdef SPI_LSB_FIRST_EN
    miso_word = 8'h80;
    send(8'h01, 1'b1, 2'd0, 1'b1);
    wait_rx(d);
    chk("lsb_mosi_stream", {24'd0, mosi_cap}, 32'h80);
    chk("lsb_rx", {24'd0, d}, 32'h01);
    wait_idle();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
